// File: rtl/uart_sync_filter.sv
// -----------------------------------------------------------------------------
// uart_sync_filter
//
// Brings NUM_CH asynchronous lines (typically UART RX) into the i_clk domain
// through a CDC_STAGES-deep flop chain. It then optionally debounces each line
// with a stability filter. A level change is accepted only after the
// synchronized value has disagreed with the current output for FILTER_LEN
// consecutive cycles. A shorter disagreement is dropped and recorded in a
// sticky glitch flag.
//
// Parameters
//   NUM_CH      number of independent channels (>= 1)
//   CDC_STAGES  synchronizer depth per channel (>= 2)
//   FILTER_LEN  consecutive cycles needed to accept a change (>= 1)
//   RST_VAL     reset level of the synchronizer stages and o_level
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_async      asynchronous channel inputs
//   i_filt_en    1 = stability filter active, 0 = synchronizer only
//   i_glitch_clr clears all o_glitch flags (a coincident set wins)
//   o_level      synchronized, filtered level (registered)
//   o_rise       one-cycle pulse when o_level goes 0->1 (registered)
//   o_fall       one-cycle pulse when o_level goes 1->0 (registered)
//   o_glitch     sticky per-channel rejected-glitch flag (registered)
// -----------------------------------------------------------------------------
module uart_sync_filter #(
  parameter int                NUM_CH     = 1,
  parameter int                CDC_STAGES = 2,
  parameter int                FILTER_LEN = 4,
  parameter logic [NUM_CH-1:0] RST_VAL    = '1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_async,
  input  logic              i_filt_en,
  input  logic              i_glitch_clr,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_glitch
);

  localparam int              CW       = $clog2(FILTER_LEN + 1);
  // Count value at which the next disagreeing sample is the FILTER_LEN-th one.
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

  // Reject configurations that cannot work at elaboration time.
  if (CDC_STAGES < 2) begin : g_bad_cdc
    $error("uart_sync_filter: CDC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filt
    $error("uart_sync_filter: FILTER_LEN must be >= 1");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("uart_sync_filter: NUM_CH must be >= 1");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    // Stage 0 is the metastability-catching flop; the last stage is s.
    logic [CDC_STAGES-1:0] sync_q, sync_d;
    logic                  s;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  glitch_q, glitch_d;
    logic                  glitch_set;

    assign s = sync_q[CDC_STAGES-1];

    always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      sync_d     = {sync_q[CDC_STAGES-2:0], i_async[ch]};
      cnt_d      = cnt_q;
      level_d    = level_q;
      glitch_set = 1'b0;

      if (!i_filt_en) begin
        // Bypass: follow the synchronizer and discard any partial count.
        level_d = s;
        cnt_d   = '0;
      end else if (s != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = s;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (cnt_q != '0) begin
        // The input fell back before the run was long enough.
        cnt_d      = '0;
        glitch_set = 1'b1;
      end

      rise_d   = level_d & ~level_q;
      fall_d   = ~level_d & level_q;
      // Set has priority over a coincident clear.
      glitch_d = (glitch_q & ~i_glitch_clr) | glitch_set;
    end

    always_ff @(posedge i_clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (i_rst) begin
        sync_q   <= {CDC_STAGES{RST_VAL[ch]}};
        cnt_q    <= '0;
        level_q  <= RST_VAL[ch];
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        cnt_q    <= cnt_d;
        level_q  <= level_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        glitch_q <= glitch_d;
      end
    end

    assign o_level[ch]  = level_q;
    assign o_rise[ch]   = rise_q;
    assign o_fall[ch]   = fall_q;
    assign o_glitch[ch] = glitch_q;
  end

endmodule

// File: tb/tb_uart_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_uart_sync_filter
//
// Bench for uart_sync_filter with NUM_CH=2, CDC_STAGES=2, FILTER_LEN=4 and
// RST_VAL=2'b11. The reference model keeps a history queue of sampled inputs
// for the synchronizer delay. It tracks, per channel, how many consecutive
// samples have disagreed with the accepted level.
// -----------------------------------------------------------------------------
module tb_uart_sync_filter;

  localparam int         NCH  = 2;
  localparam int         CDC  = 2;
  localparam int         FLEN = 4;
  localparam logic [1:0] RV   = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] async_in;
  logic [1:0] o_level, o_rise, o_fall, o_glitch;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_sync_filter #(
    .NUM_CH    (NCH),
    .CDC_STAGES(CDC),
    .FILTER_LEN(FLEN),
    .RST_VAL   (RV)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_async     (async_in),
    .i_filt_en   (en),
    .i_glitch_clr(clr),
    .o_level     (o_level),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_glitch    (o_glitch)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [1:0] hist[$];          // inputs sampled at the last CDC edges
  logic [1:0] m_level, m_rise, m_fall, m_glitch;
  int         run[2];           // consecutive samples disagreeing with m_level

  always @(posedge clk) begin
    logic [1:0] s;
    logic [1:0] prev;
    logic [1:0] set;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < CDC; k++) hist.push_back(RV);
      m_level  = RV;
      m_rise   = '0;
      m_fall   = '0;
      m_glitch = '0;
      run[0]   = 0;
      run[1]   = 0;
    end else begin
      s    = hist[0];           // the input seen CDC edges ago
      hist.push_back(async_in);
      void'(hist.pop_front());
      prev = m_level;
      set  = '0;
      for (int c = 0; c < NCH; c++) begin
        if (!en) begin
          run[c]     = 0;
          m_level[c] = s[c];
        end else if (s[c] != m_level[c]) begin
          run[c] = run[c] + 1;
          if (run[c] == FLEN) begin
            m_level[c] = s[c];
            run[c]     = 0;
          end
        end else begin
          if (run[c] > 0) set[c] = 1'b1;
          run[c] = 0;
        end
      end
      m_rise   = m_level & ~prev;
      m_fall   = ~m_level & prev;
      m_glitch = (clr ? 2'b00 : m_glitch) | set;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: apply inputs on the falling edge, then look just after the rise.
  // ---------------------------------------------------------------------------
  task automatic step(input logic [1:0] a, input logic e, input logic c,
                      input logic r);
    @(negedge clk);
    async_in = a;
    en       = e;
    clr      = c;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int fall_edge;
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b1, 1'b0, 1'b1);
      checks++;
      if (o_level !== 2'b11 || o_rise !== 2'b00 || o_fall !== 2'b00 ||
          o_glitch !== 2'b00) begin
        failures++;
        $display("FAIL reset_hold: level=%b rise=%b fall=%b glitch=%b expected 11/00/00/00",
                 o_level, o_rise, o_fall, o_glitch);
      end
    end
    fall_edge = 0;
    for (int n = 1; n <= 10; n++) begin
      step(2'b00, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({o_level, o_rise, o_fall, o_glitch} !== {m_level, m_rise, m_fall, m_glitch}) begin
        failures++;
        $display("FAIL reset_release edge %0d: got %b expected %b", n,
                 {o_level, o_rise, o_fall, o_glitch}, {m_level, m_rise, m_fall, m_glitch});
      end
      if (fall_edge == 0 && o_level === 2'b00) fall_edge = n;
    end
    checks++;
    if (fall_edge != 6) begin
      failures++;
      $display("FAIL reset_fall_edge: got edge %0d expected 6", fall_edge);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stable_change();
    int edge_at;
    int pulses;
    for (int i = 0; i < 8; i++) step(2'b11, 1'b1, 1'b0, 1'b0);
    edge_at = 0;
    pulses  = 0;
    for (int n = 1; n <= 10; n++) begin
      step(2'b10, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({o_level, o_rise, o_fall, o_glitch} !== {m_level, m_rise, m_fall, m_glitch}) begin
        failures++;
        $display("FAIL stable_change edge %0d: got %b expected %b", n,
                 {o_level, o_rise, o_fall, o_glitch}, {m_level, m_rise, m_fall, m_glitch});
      end
      if (edge_at == 0 && o_level[0] === 1'b0) edge_at = n;
      if (o_fall[0] === 1'b1) pulses++;
    end
    checks++;
    if (edge_at != 6 || pulses != 1 || o_level[1] !== 1'b1 || o_glitch !== 2'b00) begin
      failures++;
      $display("FAIL stable_change_summary: edge=%0d falls=%0d level1=%b glitch=%b expected 6/1/1/00",
               edge_at, pulses, o_level[1], o_glitch);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_glitch();
    int bad;
    for (int i = 0; i < 6; i++) step(2'b11, 1'b1, 1'b0, 1'b0);
    bad = 0;
    for (int n = 0; n < 11; n++) begin
      step((n < 3) ? 2'b01 : 2'b11, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({o_level, o_rise, o_fall, o_glitch} !== {m_level, m_rise, m_fall, m_glitch}) begin
        failures++;
        $display("FAIL glitch step %0d: got %b expected %b", n,
                 {o_level, o_rise, o_fall, o_glitch}, {m_level, m_rise, m_fall, m_glitch});
      end
      if (o_level[1] !== 1'b1 || o_fall[1] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || o_glitch !== 2'b10) begin
      failures++;
      $display("FAIL glitch_reject: level/fall disturbances=%0d glitch=%b expected 0 and 10",
               bad, o_glitch);
    end
    step(2'b11, 1'b1, 1'b1, 1'b0);
    checks++;
    if (o_glitch !== 2'b00) begin
      failures++;
      $display("FAIL glitch_clear: glitch=%b expected 00", o_glitch);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bypass();
    int edge_at;
    int rises;
    int low_cycles;
    for (int i = 0; i < 5; i++) step(2'b10, 1'b0, 1'b0, 1'b0);
    edge_at = 0;
    rises   = 0;
    for (int n = 1; n <= 6; n++) begin
      step(2'b11, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({o_level, o_rise, o_fall, o_glitch} !== {m_level, m_rise, m_fall, m_glitch}) begin
        failures++;
        $display("FAIL bypass_rise edge %0d: got %b expected %b", n,
                 {o_level, o_rise, o_fall, o_glitch}, {m_level, m_rise, m_fall, m_glitch});
      end
      if (edge_at == 0 && o_level[0] === 1'b1) edge_at = n;
      if (o_rise[0] === 1'b1) rises++;
    end
    checks++;
    if (edge_at != 3 || rises != 1) begin
      failures++;
      $display("FAIL bypass_latency: edge=%0d rises=%0d expected 3/1", edge_at, rises);
    end
    low_cycles = 0;
    for (int n = 0; n < 6; n++) begin
      step((n == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, 1'b0);
      if (o_level[0] === 1'b0) low_cycles++;
    end
    checks++;
    if (low_cycles != 1 || o_glitch !== 2'b00) begin
      failures++;
      $display("FAIL bypass_pulse: low cycles=%0d glitch=%b expected 1/00", low_cycles, o_glitch);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_collision();
    for (int i = 0; i < 6; i++) step(2'b11, 1'b1, (i == 5), 1'b0);
    // Two low samples on channel 0; the glitch is recorded at the 5th edge.
    for (int n = 1; n <= 5; n++) begin
      step((n <= 2) ? 2'b10 : 2'b11, 1'b1, 1'b1, 1'b0);
      if (n == 4) begin
        checks++;
        if (o_glitch !== 2'b00) begin
          failures++;
          $display("FAIL collision_before: glitch=%b expected 00", o_glitch);
        end
      end
    end
    checks++;
    if (o_glitch !== 2'b01 || o_glitch !== m_glitch) begin
      failures++;
      $display("FAIL collision_set_wins: glitch=%b expected 01", o_glitch);
    end
    step(2'b11, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_glitch !== 2'b01) begin
      failures++;
      $display("FAIL collision_sticky: glitch=%b expected 01", o_glitch);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_count();
    int bad;
    for (int i = 0; i < 6; i++) step(2'b11, 1'b1, (i == 5), 1'b0);
    // After four low samples the channel-0 count has reached 2.
    for (int i = 0; i < 4; i++) step(2'b10, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b1);
    checks++;
    if (o_level !== 2'b11 || o_rise !== 2'b00 || o_fall !== 2'b00 || o_glitch !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_count: level=%b rise=%b fall=%b glitch=%b expected 11/00/00/00",
               o_level, o_rise, o_fall, o_glitch);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 1'b1, 1'b0, 1'b0);
      if (o_level !== 2'b11 || o_rise !== 2'b00 || o_fall !== 2'b00 || o_glitch !== 2'b00)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid_count_after: disturbed cycles=%0d expected 0", bad);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_en_toggle();
    logic [1:0] pat [10] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11,
                             2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       ens [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) step(2'b11, 1'b1, (i == 5), 1'b0);
    for (int n = 0; n < 10; n++) begin
      step(pat[n], ens[n], 1'b0, 1'b0);
      checks++;
      if ({o_level, o_rise, o_fall, o_glitch} !== {m_level, m_rise, m_fall, m_glitch}) begin
        failures++;
        $display("FAIL en_toggle step %0d: got %b expected %b", n,
                 {o_level, o_rise, o_fall, o_glitch}, {m_level, m_rise, m_fall, m_glitch});
      end
    end
    checks++;
    if (o_glitch !== 2'b00) begin
      failures++;
      $display("FAIL en_toggle_no_glitch: glitch=%b expected 00", o_glitch);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [1:0] a;
    logic       e;
    logic       c;
    logic       r;
    int         errs;
    a    = 2'b11;
    e    = 1'b1;
    errs = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NCH; b++)
        if ($urandom_range(5) == 0) a[b] = ~a[b];
      if ($urandom_range(49) == 0) e = ~e;
      c = ($urandom_range(19) == 0);
      r = ($urandom_range(399) == 0);
      step(a, e, c, r);
      checks++;
      if ({o_level, o_rise, o_fall, o_glitch} !== {m_level, m_rise, m_fall, m_glitch}) begin
        failures++;
        if (errs < 10)
          $display("FAIL random cycle %0d: got %b expected %b", n,
                   {o_level, o_rise, o_fall, o_glitch}, {m_level, m_rise, m_fall, m_glitch});
        errs++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    clr      = 1'b0;
    async_in = 2'b11;
    test_reset();
    test_stable_change();
    test_glitch();
    test_bypass();
    test_collision();
    test_reset_mid_count();
    test_en_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_sync_filter.md
UART_SYNC_FILTER -- requirements
Module: uart_sync_filter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 1, giving the number of independent asynchronous input channels.
REQ-002 The block SHALL have parameter CDC_STAGES, default 2, giving the synchronizer flop depth per channel.
REQ-003 The block SHALL have parameter FILTER_LEN, default 4, giving the consecutive-cycle stability count required to accept a level change.
REQ-004 The block SHALL have parameter RST_VAL [NUM_CH-1:0], default all ones (UART idle), giving the reset value of the synchronizer stages and o_level.
REQ-005 Port i_clk, input, 1 bit: the single clock; all flops sample on the rising edge.
REQ-006 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port i_async, input, NUM_CH bits: asynchronous channel inputs, e.g. the RX line.
REQ-008 Port i_filt_en, input, 1 bit: 1 = stability filter active, 0 = bypass (synchronizer only).
REQ-009 Port i_glitch_clr, input, 1 bit: clears all o_glitch flags.
REQ-010 Port o_level, output, NUM_CH bits: synchronized, filtered level.
REQ-011 Port o_rise, output, NUM_CH bits: one-cycle pulse on the 0->1 transition of o_level.
REQ-012 Port o_fall, output, NUM_CH bits: one-cycle pulse on the 1->0 transition of o_level.
REQ-013 Port o_glitch, output, NUM_CH bits: sticky per-channel rejected-glitch flag.

Function
REQ-014 Elaboration SHALL fail if CDC_STAGES<2, FILTER_LEN<1, or NUM_CH<1.
REQ-015 Each channel SHALL pass i_async through a shift chain of CDC_STAGES flops; s[ch] is the last stage.
REQ-016 Each channel SHALL own a counter cnt of width $clog2(FILTER_LEN+1); all outputs SHALL be registered.
REQ-017 Filter on, s!=o_level, cnt<FILTER_LEN-1: cnt SHALL increment; o_level SHALL hold.
REQ-018 Filter on, s!=o_level, cnt==FILTER_LEN-1: o_level SHALL load s and cnt SHALL clear, both at the same edge.
REQ-019 Filter on, s==o_level, cnt>0: cnt SHALL clear and o_glitch[ch] SHALL set.
REQ-020 Filter on, s==o_level, cnt==0: no state change.
REQ-021 Latency, filter on: o_level SHALL show a stable input change at the (CDC_STAGES+FILTER_LEN)-th rising edge, counting the first edge that samples the new value as edge 1.
REQ-022 Any input pulse shorter than FILTER_LEN sampled cycles SHALL NOT change o_level.
REQ-023 Bypass (i_filt_en=0): o_level SHALL load s every cycle, cnt SHALL be forced to 0, and o_glitch SHALL NOT set; latency is CDC_STAGES+1 edges.
REQ-024 Changing i_filt_en mid-count SHALL discard the partial count with no glitch recorded; a new count starts from 0.
REQ-025 o_rise[ch]/o_fall[ch] SHALL be asserted at the same edge at which o_level[ch] changes, for exactly one cycle, in both filter and bypass modes.
REQ-026 o_glitch SHALL stay set until i_glitch_clr=1; when a set and a clear coincide, set SHALL win.
REQ-027 With FILTER_LEN=1 the filter SHALL be equivalent to bypass timing, and o_glitch SHALL never set.
REQ-028 Channels SHALL be fully independent; simultaneous events on different channels SHALL each be handled per REQ-017..026.

Reset
REQ-029 i_rst=1 at an edge SHALL load all synchronizer stages and o_level with RST_VAL, and clear cnt, o_rise, o_fall and o_glitch, regardless of any other input.
REQ-030 Reset mid-count SHALL discard the count with no glitch recorded and no edge pulse; filtering restarts from the RST_VAL level after release.

Verification (NUM_CH=2, CDC_STAGES=2, FILTER_LEN=4, RST_VAL=2'b11, i_filt_en=1 unless stated)
REQ-031 Reset: i_rst=1 for 3 cycles with i_async=2'b00 -> o_level=2'b11 and o_rise=o_fall=o_glitch=0 during reset; after release o_level[1:0] fall at edge 6.
REQ-032 Stable change: i_async[0] 1->0 held -> o_level[0]=0 at edge 6, o_fall[0]=1 for that single cycle, o_level[1] unchanged, o_glitch=0.
REQ-033 Glitch: i_async[1]=0 for 3 sampled edges, then 1 -> o_level[1] stays 1, no o_fall, o_glitch[1]=1 sticky; one-cycle i_glitch_clr -> o_glitch[1]=0 next cycle.
REQ-034 Bypass: i_filt_en=0, i_async[0] 0->1 -> o_level[0]=1 at edge 3, o_rise[0] one cycle; 1-cycle input pulse -> passes through, o_glitch stays 0.
REQ-035 Collision: a glitch completes on the same edge as i_glitch_clr=1 -> o_glitch[ch]=1.
REQ-036 Reset mid-count: i_rst=1 when cnt[0]=2 -> next cycle cnt=0, o_level=2'b11, o_glitch=0, no pulses.
